// File: rtl/hwag_pkg.sv
// Shared definitions for the hwag angle-generator front end: the blanking
// FSM state type and default widths for the VR input conditioner.
package hwag_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    BLANK = 1'b1
  } vr_blank_state_t;

  localparam int HWAG_VR_FILT_W  = 16;
  localparam int HWAG_VR_BLANK_W = 16;
  localparam int HWAG_VR_REJ_W   = 8;

endpackage

// File: rtl/hwag_sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// Used for the crank VR pin and reusable for the cam input.
module hwag_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages clear on synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hwag_vr_filter.sv
// VR input conditioner: synchronises the raw comparator pin, removes short
// glitches with a hysteresis integrator, and suppresses spurious teeth with a
// post-edge blanking window. Emits a filtered level, a one-cycle strobe on the
// accepted active edge, and a diagnostic count of edges dropped by blanking.
// Build option: HWAG_VR_FILTER_REJ_CNT_EN enables the rejected-edge counter;
// without it rej_cnt reads 0 and rej_clr is ignored.
module hwag_vr_filter
  import hwag_pkg::*;
#(
  parameter int FILT_W  = HWAG_VR_FILT_W,
  parameter int BLANK_W = HWAG_VR_BLANK_W,
  parameter int REJ_W   = HWAG_VR_REJ_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               vr_in,
  input  logic               edge_pol,
  input  logic [FILT_W-1:0]  filt_top,
  input  logic [BLANK_W-1:0] blank_top,
  input  logic               rej_clr,
  output logic               vr_out,
  output logic               vr_edge,
  output logic               blanking,
  output logic [REJ_W-1:0]   rej_cnt
);

  localparam logic [FILT_W-1:0]  FILT_ONE  = FILT_W'(1);
  localparam logic [BLANK_W-1:0] BLANK_ONE = BLANK_W'(1);

  logic                 vr_s;
  logic [FILT_W-1:0]    icnt;
  logic [FILT_W-1:0]    icnt_nxt;
  logic [FILT_W-1:0]    eff_top;
  logic                 vr_out_nxt;
  logic                 act;
  logic                 rej_inc;
  logic [BLANK_W-1:0]   bcnt;
  vr_blank_state_t      state;

  hwag_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (vr_in),
    .q   (vr_s)
  );

  // Integrator next state and hysteresis decision; a threshold lowered below
  // the running count snaps the count to the new rail without moving vr_out.
  always_comb begin
    eff_top    = (filt_top == '0) ? FILT_ONE : filt_top;
    icnt_nxt   = icnt;
    vr_out_nxt = vr_out;
    if (icnt > eff_top) begin
      icnt_nxt = eff_top;
    end else begin
      if (vr_s && (icnt < eff_top)) begin
        icnt_nxt = icnt + FILT_ONE;
      end else if (!vr_s && (icnt != '0)) begin
        icnt_nxt = icnt - FILT_ONE;
      end
      if ((icnt_nxt == eff_top) && (icnt != eff_top)) begin
        vr_out_nxt = 1'b1;
      end else if ((icnt_nxt == '0) && (icnt != '0)) begin
        vr_out_nxt = 1'b0;
      end
    end
    act     = en && (vr_out_nxt != vr_out) && (vr_out_nxt == edge_pol);
    rej_inc = act && (state == BLANK);
  end

  // Integrator and filtered level; disable parks both at zero.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      icnt   <= '0;
      vr_out <= 1'b0;
    end else begin
      icnt   <= icnt_nxt;
      vr_out <= vr_out_nxt;
    end
  end

  // Blanking FSM: strobe accepted edges, then hold off for blank_top clocks.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state   <= ARMED;
      bcnt    <= '0;
      vr_edge <= 1'b0;
    end else begin
      vr_edge <= 1'b0;
      case (state)
        ARMED: begin
          if (act) begin
            vr_edge <= 1'b1;
            if (blank_top != '0) begin
              bcnt  <= blank_top;
              state <= BLANK;
            end
          end
        end
        BLANK: begin
          if (bcnt <= BLANK_ONE) begin
            bcnt  <= '0;
            state <= ARMED;
          end else begin
            bcnt <= bcnt - BLANK_ONE;
          end
        end
        default: begin
          bcnt  <= '0;
          state <= ARMED;
        end
      endcase
    end
  end

  assign blanking = (state == BLANK);

`ifdef HWAG_VR_FILTER_REJ_CNT_EN
  localparam logic [REJ_W-1:0] REJ_MAX = '1;
  localparam logic [REJ_W-1:0] REJ_ONE = REJ_W'(1);

  // Saturating reject counter; a clear wins over a same-cycle reject.
  always_ff @(posedge clk) begin
    if (rst || rej_clr) begin
      rej_cnt <= '0;
    end else if (rej_inc && (rej_cnt != REJ_MAX)) begin
      rej_cnt <= rej_cnt + REJ_ONE;
    end
  end
`else
  logic unused_rej;
  assign unused_rej = rej_clr ^ rej_inc;
  assign rej_cnt    = '0;
`endif

endmodule

// File: tb/tb_hwag_vr_filter.sv
// Bench for hwag_vr_filter: directed pulse trains on vr_in, a behavioural
// model (integer integrator plus timestamp-based blanking window) compared on
// every cycle, and literal expectations for latency, strobe counts and
// reject counts.
module tb_hwag_vr_filter;

  localparam int REJ_MAX = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        vr_in;
  logic        edge_pol;
  logic [15:0] filt_top;
  logic [15:0] blank_top;
  logic        rej_clr;
  logic        vr_out;
  logic        vr_edge;
  logic        blanking;
  logic [7:0]  rej_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  int ecnt = 0;

  always #5 clk = ~clk;

  hwag_vr_filter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .vr_in     (vr_in),
    .edge_pol  (edge_pol),
    .filt_top  (filt_top),
    .blank_top (blank_top),
    .rej_clr   (rej_clr),
    .vr_out    (vr_out),
    .vr_edge   (vr_edge),
    .blanking  (blanking),
    .rej_cnt   (rej_cnt)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint cyc = 0;
  bit     m_s1, m_s2, m_out, m_edge, m_blank, m_has;
  int     m_icnt, m_rej, m_len;
  longint m_last;
  int     et, nx_icnt;
  bit     nx_out, act, blk, nx_acc, nx_rinc, nx_blank;

  always_comb begin
    et       = (filt_top == 16'd0) ? 1 : int'(filt_top);
    nx_icnt  = m_icnt;
    nx_out   = m_out;
    if (m_icnt > et) begin
      nx_icnt = et;
    end else begin
      if (m_s2 && m_icnt < et) nx_icnt = m_icnt + 1;
      else if (!m_s2 && m_icnt > 0) nx_icnt = m_icnt - 1;
      if (nx_icnt == et && m_icnt != et) nx_out = 1'b1;
      else if (nx_icnt == 0 && m_icnt != 0) nx_out = 1'b0;
    end
    act      = (nx_out != m_out) && (nx_out == edge_pol);
    blk      = m_has && ((cyc - m_last) <= longint'(m_len));
    nx_acc   = en && act && !blk;
    nx_rinc  = en && act && blk;
    nx_blank = nx_acc ? (blank_top != 16'd0)
                      : (m_has && ((cyc - m_last) < longint'(m_len)));
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_s1 <= 0; m_s2 <= 0; m_icnt <= 0; m_out <= 0; m_edge <= 0;
      m_blank <= 0; m_has <= 0; m_rej <= 0;
    end else begin
      m_s1 <= vr_in;
      m_s2 <= m_s1;
      if (!en) begin
        m_icnt <= 0; m_out <= 0; m_edge <= 0; m_blank <= 0; m_has <= 0;
      end else begin
        m_icnt  <= nx_icnt;
        m_out   <= nx_out;
        m_edge  <= nx_acc;
        m_blank <= nx_blank;
        if (nx_acc) begin
          m_has  <= 1'b1;
          m_last <= cyc;
          m_len  <= int'(blank_top);
        end
      end
`ifdef HWAG_VR_FILTER_REJ_CNT_EN
      if (rej_clr) m_rej <= 0;
      else if (nx_rinc && m_rej < REJ_MAX) m_rej <= m_rej + 1;
`endif
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("vr_out", vr_out, m_out);
      check("vr_edge", vr_edge, m_edge);
      check("blanking", blanking, m_blank);
      check("rej_cnt", rej_cnt, m_rej);
    end
  end

  always @(negedge clk) if (vr_edge === 1'b1) ecnt <= ecnt + 1;

  // ---------------- stimulus helpers ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    vr_in = 1'b1;
    wait_n(h);
    vr_in = 1'b0;
    wait_n(l);
  endtask

  // Counts posedges from now until vr_out reaches lvl; also reports strobes seen.
  task automatic measure(input bit lvl, output int n, output int strobes, output bit strobe_at_end);
    n = 0; strobes = 0; strobe_at_end = 1'b0;
    while (n < 50) begin
      @(posedge clk); #1;
      n++;
      if (vr_edge) strobes++;
      if (vr_out == lvl) begin
        strobe_at_end = vr_edge;
        break;
      end
    end
  endtask

  task automatic wait_strobe(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (vr_edge) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  int n, s, e0;
  bit se, ok;
  int rej_exp;

  initial begin
    rst = 1; en = 0; vr_in = 0; edge_pol = 1; filt_top = 16'd3;
    blank_top = 16'd0; rej_clr = 0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    wait_n(3);
    rst = 0; en = 1;
    @(posedge clk); #1;
    check("reset_vr_out", vr_out, 0);
    check("reset_blanking", blanking, 0);
    check("reset_rej", rej_cnt, 0);
    wait_n(5);

    // Latency, rising then falling, filt_top=3, no blanking.
    vr_in = 1'b1;
    measure(1'b1, n, s, se);
    check("rise_latency_edges", n, 5);
    check("rise_strobe_coincides", se, 1);
    @(posedge clk); #1;
    check("rise_strobe_width", vr_edge, 0);
    @(negedge clk);
    vr_in = 1'b0;
    measure(1'b0, n, s, se);
    check("fall_latency_edges", n, 5);
    check("fall_no_strobe", s, 0);
    wait_n(5);

    // Falling polarity: strobe only on the fall.
    edge_pol = 1'b0;
    e0 = ecnt;
    pulse(8, 10);
    check("falling_pol_strobes", ecnt - e0, 1);
    edge_pol = 1'b1;

    // Glitch: 2-clock pulse never reaches the rail of 3.
    e0 = ecnt;
    pulse(2, 10);
    check("glitch_vr_out", vr_out, 0);
    check("glitch_strobes", ecnt - e0, 0);

    // Threshold lowered under a running count: snap without a level change.
    filt_top = 16'd8;
    vr_in = 1'b1;
    wait_n(6);
    filt_top = 16'd2;
    wait_n(10);
    check("lowered_top_vr_out", vr_out, 0);
    vr_in = 1'b0;
    wait_n(6);
    filt_top = 16'd3;
    wait_n(4);

    // Blanking, blank_top=20: spacings 10 (rejected) and 25 (accepted).
    blank_top = 16'd20;
    rej_clr = 1'b1; wait_n(1); rej_clr = 1'b0;
    e0 = ecnt;
    pulse(5, 5);
    pulse(5, 10);
    pulse(5, 30);
    check("blank_10_25_strobes", ecnt - e0, 2);
`ifdef HWAG_VR_FILTER_REJ_CNT_EN
    rej_exp = 1;
`else
    rej_exp = 0;
`endif
    check("blank_10_rej", rej_cnt, rej_exp);

    // Active edge exactly on the final blanking edge is rejected.
    e0 = ecnt;
    pulse(5, 15);
    pulse(5, 16);
    pulse(5, 30);
    check("blank_boundary_strobes", ecnt - e0, 2);
    check("blank_boundary_rej", rej_cnt, 2 * rej_exp);

    // Reset mid-blank with vr_out high.
    vr_in = 1'b1;
    wait_strobe(20, ok);
    check("pre_reset_strobe_seen", ok, 1);
    wait_n(3);
    check("pre_reset_blanking", blanking, 1);
    check("pre_reset_vr_out", vr_out, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_vr_out", vr_out, 0);
    check("reset_mid_blanking", blanking, 0);
    check("reset_mid_vr_edge", vr_edge, 0);
    check("reset_mid_rej", rej_cnt, 0);
    wait_n(3);
    rst = 1'b0;
    vr_in = 1'b0;
    wait_n(30);

    // Disable mid-blank clears the window; re-enable re-arms immediately.
    e0 = ecnt;
    vr_in = 1'b1;
    wait_strobe(20, ok);
    wait_n(2);
    en = 1'b0;
    @(posedge clk); #1;
    check("disable_blanking", blanking, 0);
    check("disable_vr_out", vr_out, 0);
    @(negedge clk);
    en = 1'b1;
    wait_n(8);
    check("reenable_strobes", ecnt - e0, 2);
    vr_in = 1'b0;
    wait_n(30);

    // 60-2 wheel, 256 clocks per tooth, blank_top=64.
    blank_top = 16'd64;
    rej_clr = 1'b1; wait_n(1); rej_clr = 1'b0;
    e0 = ecnt;
    for (int t = 0; t < 58; t++) pulse(128, 128);
    wait_n(512);
    check("wheel_strobes", ecnt - e0, 58);
    check("wheel_rej", rej_cnt, 0);

    // Saturating counter: one accepted edge then 300 rejects.
    filt_top = 16'd1;
    blank_top = 16'hFFFF;
    e0 = ecnt;
    for (int p = 0; p < 301; p++) pulse(2, 2);
    check("sat_strobes", ecnt - e0, 1);
`ifdef HWAG_VR_FILTER_REJ_CNT_EN
    check("sat_rej", rej_cnt, 255);
`else
    check("sat_rej", rej_cnt, 0);
`endif
    rej_clr = 1'b1;
    pulse(2, 2);
    pulse(2, 2);
    rej_clr = 1'b0;
    wait_n(2);
    check("clr_with_reject", rej_cnt, 0);
    en = 1'b0;
    wait_n(2);
    check("disable_rej_holds", rej_cnt, 0);
    en = 1'b1;
    wait_n(4);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
